// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port among NUM_REQ requesters
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4,
  parameter int CNT_W      = 3,
  parameter int ID_W       = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          wr_en,
  output logic [DATA_WIDTH-1:0]         buff_in,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [CNT_W-1:0]              burst_cnt
);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0] owner_q, owner_d, rr_ptr_q, rr_ptr_d, pick, next_ptr;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic any_req, busy, owner_valid, xfer, last_beat;
  always_comb begin
    any_req = 1'b0;
    pick = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
        any_req = 1'b1;
        pick = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
  end
  assign busy        = rst && state_q == BURST;
  assign owner_valid = req_valid[owner_q];
  assign xfer        = busy && owner_valid && !fifo_full;
  assign last_beat   = burst_cnt_q == CNT_W'(MAX_BURST - 1);
  assign next_ptr    = owner_q == ID_W'(NUM_REQ - 1) ? '0 : owner_q + ID_W'(1);
  assign req_ready   = busy && !fifo_full ? gnt_q : '0;
  assign wr_en       = xfer;
  assign buff_in     = req_data[owner_q*DATA_WIDTH +: DATA_WIDTH];
  assign gnt         = gnt_q;
  assign burst_cnt   = burst_cnt_q;
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    owner_d = owner_q;
    rr_ptr_d = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    if (state_q == IDLE) begin
      if (any_req) begin
        state_d = BURST;
        gnt_d = NUM_REQ'(1) << pick;
        owner_d = pick;
        burst_cnt_d = '0;
      end
    end else if (!owner_valid || (xfer && last_beat)) begin
      state_d = IDLE;
      gnt_d = '0;
      rr_ptr_d = next_ptr;
      burst_cnt_d = '0;
    end else if (xfer) begin
      burst_cnt_d = burst_cnt_q + CNT_W'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q <= '0;
      owner_q <= '0;
      rr_ptr_q <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      owner_q <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end
endmodule
